// File: rtl/interrupt_arbiter_prio_rr_pkg.sv
// Shared types and sizing for the priority / round-robin interrupt arbiter.
package InterruptArbiterPkg;

    localparam int NUM_INT_PORTS = 16;
    localparam int PRIO_W        = 3;

    typedef enum logic [1:0] {
        IDLE,
        OFFER,
        SERVICE
    } arb_state_e;

    typedef logic [$clog2(NUM_INT_PORTS)-1:0] int_id_t;

endpackage

// File: rtl/int_arb_winner_sel.sv
// Combinational winner select: highest priority, ties broken from rr_ptr upward.
module int_arb_winner_sel #(
    parameter int NUM_PORTS = InterruptArbiterPkg::NUM_INT_PORTS,
    parameter int PRIO_W    = InterruptArbiterPkg::PRIO_W,
    parameter int ID_W      = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0]        eligible_i,
    input  logic [NUM_PORTS*PRIO_W-1:0] prio_i,
    input  logic [ID_W-1:0]             rr_ptr_i,
    output logic                        found_o,
    output logic [ID_W-1:0]             id_o,
    output logic [PRIO_W-1:0]           prio_o
);

    logic [PRIO_W-1:0] prio_a [NUM_PORTS];
    logic [ID_W:0]     sum;
    logic [ID_W-1:0]   idx;

    always_comb begin
        for (int k = 0; k < NUM_PORTS; k++) begin
            prio_a[k] = prio_i[k*PRIO_W +: PRIO_W];
        end
    end

    // Scan in rotated order; strict '>' keeps the first index among equals.
    always_comb begin
        found_o = 1'b0;
        id_o    = '0;
        prio_o  = '0;
        sum     = '0;
        idx     = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            sum = {1'b0, rr_ptr_i} + (ID_W+1)'(i);
            if (sum >= (ID_W+1)'(NUM_PORTS)) begin
                sum = sum - (ID_W+1)'(NUM_PORTS);
            end
            idx = sum[ID_W-1:0];
            if (eligible_i[idx] && (!found_o || (prio_a[idx] > prio_o))) begin
                found_o = 1'b1;
                id_o    = idx;
                prio_o  = prio_a[idx];
            end
        end
    end

endmodule

// File: rtl/interrupt_arbiter_prio_rr.sv
// Interrupt arbiter: pending capture, eligibility, offer/claim handshake, service tracking.
module interrupt_arbiter_prio_rr
    import InterruptArbiterPkg::*;
#(
    parameter int NUM_PORTS = InterruptArbiterPkg::NUM_INT_PORTS,
    parameter int PRIO_W    = InterruptArbiterPkg::PRIO_W,
    parameter int ID_W      = $clog2(NUM_PORTS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS-1:0]        irq_i,
    input  logic [NUM_PORTS-1:0]        edge_mode_i,
    input  logic [NUM_PORTS-1:0]        mask_i,
    input  logic [NUM_PORTS*PRIO_W-1:0] prio_i,
    input  logic [PRIO_W-1:0]           thresh_i,
    output logic                        req_valid_o,
    output logic [ID_W-1:0]             req_id_o,
    output logic [PRIO_W-1:0]           req_prio_o,
    input  logic                        req_ready_i,
    input  logic                        done_valid_i,
    input  logic [ID_W-1:0]             done_id_i,
    output logic [NUM_PORTS-1:0]        pending_o,
    output logic                        busy_o
);

    arb_state_e           state_q;
    logic [NUM_PORTS-1:0] irq_q, pending_q, pending_d;
    logic [NUM_PORTS-1:0] in_service_q, in_service_d;
    logic [NUM_PORTS-1:0] eligible, rise, id_mask;
    logic                 valid_q, busy_q;
    logic [ID_W-1:0]      id_q, rr_q;
    logic [PRIO_W-1:0]    prio_q;
    logic                 found, claim, done_hit;
    logic [ID_W-1:0]      win_id;
    logic [PRIO_W-1:0]    win_prio;

    assign claim    = (state_q == OFFER) && req_ready_i;
    assign done_hit = (state_q == SERVICE) && done_valid_i && (done_id_i == id_q);
    assign id_mask  = NUM_PORTS'(1) << id_q;
    assign rise     = irq_i & ~irq_q;

    // A fresh edge in the claim cycle outranks the clear.
    assign pending_d = (edge_mode_i & ((pending_q & ~(claim ? id_mask : '0)) | rise))
                     | (~edge_mode_i & irq_i);

    always_comb begin
        in_service_d = in_service_q;
        if (claim) begin
            in_service_d = in_service_d | id_mask;
        end
        if (done_hit) begin
            in_service_d = in_service_d & ~id_mask;
        end
    end

    always_comb begin
        eligible = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            eligible[k] = pending_q[k] & ~mask_i[k] & ~in_service_q[k]
                        & (prio_i[k*PRIO_W +: PRIO_W] > thresh_i);
        end
    end

    int_arb_winner_sel #(
        .NUM_PORTS (NUM_PORTS),
        .PRIO_W    (PRIO_W),
        .ID_W      (ID_W)
    ) u_sel (
        .eligible_i (eligible),
        .prio_i     (prio_i),
        .rr_ptr_i   (rr_q),
        .found_o    (found),
        .id_o       (win_id),
        .prio_o     (win_prio)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_q        <= '0;
            pending_q    <= '0;
            in_service_q <= '0;
        end else begin
            irq_q        <= irq_i;
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            id_q    <= '0;
            prio_q  <= '0;
            rr_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (found) begin
                        state_q <= OFFER;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        id_q    <= win_id;
                        prio_q  <= win_prio;
                    end
                end
                OFFER: begin
                    if (req_ready_i) begin
                        state_q <= SERVICE;
                        valid_q <= 1'b0;
                        rr_q    <= (id_q == ID_W'(NUM_PORTS-1)) ? '0 : id_q + ID_W'(1);
                    end
                end
                SERVICE: begin
                    if (done_hit) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign req_valid_o = valid_q;
    assign req_id_o    = id_q;
    assign req_prio_o  = prio_q;
    assign pending_o   = pending_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_interrupt_arbiter_prio_rr.sv
// Randomized and directed bench for interrupt_arbiter_prio_rr against a behavioural model.
module tb_interrupt_arbiter_prio_rr;

    localparam int N  = 16;
    localparam int PW = 3;
    localparam int IW = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    irq = '0, em = '0, mask = '0;
    logic [N*PW-1:0] prio = '0;
    logic [PW-1:0]   thr = '0;
    logic            ready = 1'b0, dv = 1'b0;
    logic [IW-1:0]   did = '0;
    logic            req_valid, busy;
    logic [IW-1:0]   req_id;
    logic [PW-1:0]   req_prio;
    logic [N-1:0]    pending;

    int n_vec = 0;
    int n_err = 0;

    bit m_irq_q [N];
    bit m_pend  [N];
    bit m_valid, m_serving;
    int m_id, m_prio, m_rr;

    int dut_offers [$];
    bit prev_valid;

    interrupt_arbiter_prio_rr dut (
        .clk          (clk),
        .rst          (rst),
        .irq_i        (irq),
        .edge_mode_i  (em),
        .mask_i       (mask),
        .prio_i       (prio),
        .thresh_i     (thr),
        .req_valid_o  (req_valid),
        .req_id_o     (req_id),
        .req_prio_o   (req_prio),
        .req_ready_i  (ready),
        .done_valid_i (dv),
        .done_id_i    (did),
        .pending_o    (pending),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int prio_of(int k);
        return int'(prio[k*PW +: PW]);
    endfunction

    function automatic bit elig(int k);
        return m_pend[k] && !mask[k] && !(m_serving && m_id == k)
            && (prio_of(k) > int'(thr));
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_irq_q[k] = 0;
            m_pend[k]  = 0;
        end
        m_valid = 0; m_serving = 0;
        m_id = 0; m_prio = 0; m_rr = 0;
    endtask

    task automatic model_step();
        bit np [N];
        int best, win, k;
        bit claim;
        best = -1;
        win  = -1;
        for (int j = 0; j < N; j++) begin
            if (elig(j) && prio_of(j) > best) best = prio_of(j);
        end
        if (best >= 0) begin
            for (int i = 0; i < N; i++) begin
                k = (m_rr + i) % N;
                if (elig(k) && prio_of(k) == best) begin
                    win = k;
                    break;
                end
            end
        end
        claim = m_valid && ready;
        for (int j = 0; j < N; j++) begin
            if (em[j]) np[j] = (m_pend[j] && !(claim && m_id == j)) || (irq[j] && !m_irq_q[j]);
            else       np[j] = irq[j];
        end
        if (m_valid) begin
            if (ready) begin
                m_valid   = 0;
                m_serving = 1;
                m_rr      = (m_id + 1) % N;
            end
        end else if (m_serving) begin
            if (dv && int'(did) == m_id) m_serving = 0;
        end else if (win >= 0) begin
            m_valid = 1;
            m_id    = win;
            m_prio  = best;
        end
        for (int j = 0; j < N; j++) begin
            m_pend[j]  = np[j];
            m_irq_q[j] = irq[j];
        end
    endtask

    task automatic compare();
        logic [N-1:0] pv;
        for (int k = 0; k < N; k++) pv[k] = m_pend[k];
        chk("valid", req_valid, m_valid);
        chk("busy", busy, m_valid || m_serving);
        chk("pending", pending, pv);
        if (m_valid) begin
            chk("req_id", req_id, m_id);
            chk("req_prio", req_prio, m_prio);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        @(negedge clk);
        compare();
        if (req_valid && !prev_valid) dut_offers.push_back(int'(req_id));
        prev_valid = req_valid;
    endtask

    task automatic set_prio(int k, int p);
        prio[k*PW +: PW] = PW'(p);
    endtask

    task automatic do_reset();
        irq = '0; mask = '0; em = '0; prio = '0; thr = '0;
        ready = 0; dv = 0; did = '0;
        @(negedge clk);
        rst = 1;
        #1;
        model_reset();
        compare();
        tick();
        rst = 0;
        prev_valid = 0;
        dut_offers.delete();
    endtask

    task automatic wait_offer(string tag, int max);
        int c;
        c = 0;
        while (!req_valid && c < max) begin
            tick();
            c++;
        end
        chk(tag, req_valid, 1);
    endtask

    task automatic run_prompt(int cycles);
        for (int c = 0; c < cycles; c++) begin
            dv  = m_serving;
            did = IW'(m_id);
            tick();
        end
        dv = 0;
    endtask

    int cnt;

    initial begin
        model_reset();
        prev_valid = 0;

        // reset state
        do_reset();
        chk("rst_valid", req_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pend", pending, 0);

        // edge pulse on port 3: pending at t+1, offer at t+2
        em[3] = 1; set_prio(3, 5);
        irq[3] = 1;
        tick();
        irq[3] = 0;
        chk("lat_pend", pending[3], 1);
        chk("lat_novalid", req_valid, 0);
        tick();
        chk("lat_valid", req_valid, 1);
        chk("lat_id", req_id, 3);
        chk("lat_prio", req_prio, 5);
        ready = 1;
        tick();
        ready = 0;
        chk("svc_busy", busy, 1);
        chk("svc_novalid", req_valid, 0);
        chk("svc_pendclr", pending[3], 0);
        tick(); tick();
        chk("svc_busy2", busy, 1);
        dv = 1; did = 3;
        tick();
        dv = 0;
        chk("done_idle", busy, 0);

        // round-robin rotation among equal priorities
        do_reset();
        set_prio(2, 4); set_prio(7, 4); set_prio(9, 4);
        irq[2] = 1; irq[7] = 1; irq[9] = 1;
        ready = 1;
        run_prompt(20);
        chk("rot_cnt", dut_offers.size() >= 4, 1);
        if (dut_offers.size() >= 4) begin
            chk("rot0", dut_offers[0], 2);
            chk("rot1", dut_offers[1], 7);
            chk("rot2", dut_offers[2], 9);
            chk("rot3", dut_offers[3], 2);
        end

        // priority and threshold
        do_reset();
        set_prio(1, 6); set_prio(10, 2);
        irq[1] = 1; irq[10] = 1; thr = 3;
        ready = 1;
        run_prompt(30);
        chk("thr_cnt", dut_offers.size() >= 2, 1);
        if (dut_offers.size() >= 1) chk("thr_first", dut_offers[0], 1);
        cnt = 0;
        foreach (dut_offers[i]) if (dut_offers[i] == 10) cnt++;
        chk("thr_block", cnt, 0);

        // offer held stable without withdrawal
        do_reset();
        em[5] = 1; set_prio(5, 3);
        em[0] = 1; set_prio(0, 7);
        irq[5] = 1;
        tick();
        irq[5] = 0;
        wait_offer("hold_to", 5);
        mask[5] = 1;
        irq[0] = 1;
        for (int c = 0; c < 10; c++) begin
            tick();
            irq[0] = 0;
            chk("hold_id", req_id, 5);
            chk("hold_valid", req_valid, 1);
        end
        ready = 1;
        tick();
        ready = 0;
        dv = 1; did = 5;
        tick();
        dv = 0;
        wait_offer("next_to", 5);
        chk("next_id", req_id, 0);

        // mismatched done ignored; edge during service re-offered
        do_reset();
        em[4] = 1; set_prio(4, 2);
        irq[4] = 1;
        tick();
        irq[4] = 0;
        wait_offer("svc4_to", 5);
        ready = 1;
        tick();
        ready = 0;
        dv = 1; did = 6;
        tick();
        dv = 0;
        chk("bad_done", busy, 1);
        irq[4] = 1;
        tick();
        irq[4] = 0;
        tick();
        chk("svc_edge_pend", pending[4], 1);
        chk("svc_edge_noval", req_valid, 0);
        dv = 1; did = 4;
        tick();
        dv = 0;
        chk("good_done", busy, 0);
        wait_offer("reoffer_to", 5);
        chk("reoffer_id", req_id, 4);

        // reset during offer, line held high on edge port
        do_reset();
        em[8] = 1; set_prio(8, 1);
        irq[8] = 1;
        wait_offer("rstoff_to", 5);
        rst = 1;
        #1;
        chk("rst_mid_valid", req_valid, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_pend", pending, 0);
        model_reset();
        tick();
        rst = 0;
        prev_valid = 0;
        dut_offers.delete();
        ready = 1;
        run_prompt(30);
        cnt = 0;
        foreach (dut_offers[i]) if (dut_offers[i] == 8) cnt++;
        chk("rst_one_offer", cnt, 1);

        // randomized traffic against the model
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            if (c % 200 == 0) begin
                em   = N'($urandom);
                prio = (N*PW)'({$urandom, $urandom});
                thr  = PW'($urandom_range(0, 2));
            end
            irq   = N'($urandom) & N'($urandom);
            mask  = N'($urandom) & N'($urandom) & N'($urandom);
            ready = ($urandom % 3) != 0;
            if (m_serving && ($urandom % 4) == 0) begin
                dv = 1; did = IW'(m_id);
            end else if (($urandom % 8) == 0) begin
                dv = 1; did = IW'($urandom);
            end else begin
                dv = 0;
            end
            if (c == 1000) begin
                rst = 1;
                tick();
                rst = 0;
                prev_valid = 0;
            end else begin
                tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
